// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller driving an external N-bit DAC, MSB first.
// done pulses N+1 edges after start is accepted; start is ignored while busy (no queuing).
module sar_adc_ctrl #(
  parameter int  N          = 12,
  parameter real CMP_OFFSET = 0.0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [63:0]  vin_bits,
  input  logic [63:0]  dac_vout_bits,
  output logic [N-1:0] dac_code,
  output logic [N-1:0] dout,
  output logic         busy,
  output logic         done
);

  localparam int BW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, SAMPLE, CONV, DONE} state_t;

  state_t         state, state_nx;
  logic [63:0]    vin_held, vin_held_nx;
  logic [BW-1:0]  bit_idx, bit_idx_nx;
  logic [N-1:0]   dac_code_nx, dout_nx, mask, trial;
  logic           busy_nx, done_nx, keep;

  // Ideal comparator; equality keeps the trial bit.
  always_comb begin
    keep = ($bitstoreal(vin_held) >= ($bitstoreal(dac_vout_bits) + CMP_OFFSET));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      vin_held <= 64'h0;  // bit pattern of 0.0
      bit_idx  <= BW'(N - 1);
      dac_code <= '0;
      dout     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      vin_held <= vin_held_nx;
      bit_idx  <= bit_idx_nx;
      dac_code <= dac_code_nx;
      dout     <= dout_nx;
      busy     <= busy_nx;
      done     <= done_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    vin_held_nx = vin_held;
    bit_idx_nx  = bit_idx;
    dac_code_nx = dac_code;
    dout_nx     = dout;
    busy_nx     = busy;
    done_nx     = 1'b0;
    mask        = N'(1) << bit_idx;
    trial       = dac_code;

    case (state)
      IDLE: begin
        dac_code_nx = '0;
        if (start) begin
          state_nx = SAMPLE;
          busy_nx  = 1'b1;
        end
      end
      SAMPLE: begin
        vin_held_nx = vin_bits;
        dac_code_nx = N'(1) << (N - 1);
        bit_idx_nx  = BW'(N - 1);
        state_nx    = CONV;
      end
      CONV: begin
        // Resolve bit b, then raise the next trial bit below it.
        if (!keep)
          trial = trial & ~mask;
        if (bit_idx != '0) begin
          trial      = trial | (mask >> 1);
          bit_idx_nx = bit_idx - 1'b1;
        end else begin
          dout_nx  = trial;
          done_nx  = 1'b1;
          state_nx = DONE;
        end
        dac_code_nx = trial;
      end
      DONE: begin
        busy_nx     = 1'b0;
        dac_code_nx = '0;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl closing the loop through a behavioural 12-bit, 1.2 V DAC.
// Ideal and slightly mismatched (MSB-heavy, still monotonic) DAC models are selectable.
module tb_sar_adc_ctrl;

  localparam int N = 12;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [63:0]  vin_bits;
  logic [63:0]  dac_vout_bits;
  logic [N-1:0] dac_code;
  logic [N-1:0] dout;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;
  bit mismatch_dac = 1'b0;
  logic [N-1:0] trace [0:40];

  typedef struct {
    real          vin;
    logic [N-1:0] exp;
    string        name;
  } vec_t;

  vec_t vecs [0:7];

  sar_adc_ctrl #(.N(N), .CMP_OFFSET(0.0)) dut (
    .clk(clk), .rst(rst), .start(start), .vin_bits(vin_bits),
    .dac_vout_bits(dac_vout_bits), .dac_code(dac_code), .dout(dout),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic real dac_volts(input logic [N-1:0] c, input bit mm);
    real v;
    v = 0.0;
    if (!mm) begin
      v = (real'(c) * 1.2) / 4096.0;
    end else begin
      for (int i = 0; i < N; i++)
        if (c[i]) v = v + (1.2 / 4096.0) * (2.0 ** i) * ((i >= 8) ? 1.0005 : 1.0);
    end
    return v;
  endfunction

  always_comb dac_vout_bits = $realtobits(dac_volts(dac_code, mismatch_dac));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_vec(input int i, input real v, input logic [N-1:0] e, input string nm);
    vecs[i].vin  = v;
    vecs[i].exp  = e;
    vecs[i].name = nm;
  endtask

  // One conversion from IDLE. lat = number of edges after the accepting edge until done.
  task automatic convert(input real v, input bit poke_start,
                         output logic [N-1:0] res, output int lat);
    logic [N-1:0] prev;
    prev = dout;
    lat  = -1;
    @(negedge clk);
    vin_bits = $realtobits(v);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_on_accept", busy, 1);
    for (int k = 1; k <= 40; k++) begin
      start = (poke_start && k == 5);
      @(negedge clk);
      if (k == 1) vin_bits = $realtobits(-v - 0.5);  // input moves after sampling
      trace[k] = dac_code;
      if (done) begin
        lat = k;
        break;
      end
      check("busy_mid_conv", busy, 1);
      check("dout_hold_mid_conv", dout, prev);
    end
    start = 1'b0;
    res = dout;
    check("busy_with_done", busy, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
    check("dac_code_idle", dac_code, 0);
  endtask

  initial begin
    logic [N-1:0] res;
    logic [N-1:0] prev_code;
    logic [N-1:0] exp_trace [0:12];
    int lat, ndone, first_done, second_done, ideal, diff, wait_cnt;

    set_vec(0, 0.6,   12'h800, "vin_0p6");
    set_vec(1, 0.3,   12'h400, "vin_0p3");
    set_vec(2, 0.9,   12'hC00, "vin_0p9");
    set_vec(3, -0.1,  12'h000, "vin_neg");
    set_vec(4, 1.3,   12'hFFF, "vin_over");
    set_vec(5, 0.0,   12'h000, "vin_zero");
    set_vec(6, (4095.0 * 1.2) / 4096.0, 12'hFFF, "vin_fullscale_eq");
    set_vec(7, 0.45,  12'h600, "vin_0p45");
    exp_trace = '{12'h000, 12'h800, 12'h400, 12'h600, 12'h700, 12'h680, 12'h640,
                  12'h620, 12'h610, 12'h608, 12'h604, 12'h602, 12'h601};

    // Power-up reset
    rst = 1'b1; start = 1'b0; vin_bits = 64'h0;
    #12;
    check("rst_dac_code", dac_code, 0);
    check("rst_dout", dout, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven conversions with the ideal DAC
    for (int i = 0; i < 8; i++) begin
      convert(vecs[i].vin, (i == 2), res, lat);
      check({vecs[i].name, "_code"}, res, vecs[i].exp);
      check({vecs[i].name, "_latency"}, lat, N + 1);
    end

    // Trace of the last conversion (0.45 V)
    for (int k = 1; k <= 12; k++)
      check($sformatf("trace_0p45_%0d", k), trace[k], exp_trace[k]);
    check("trace_0p45_final", trace[13], 12'h600);

    // Reset in idle clears the held result
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("idle_rst_dout", dout, 0);
    check("idle_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;

    // start held high for 40 cycles: conversions re-accepted 15 cycles apart
    vin_bits = $realtobits(0.6);
    start = 1'b1;
    ndone = 0; first_done = -1; second_done = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = k;
        else if (second_done < 0) second_done = k;
      end
    end
    start = 1'b0;
    check("held_start_done_count", ndone, 2);
    check("held_start_spacing", second_done - first_done, N + 3);
    check("held_start_code", dout, 12'h800);
    wait_cnt = 0;
    while (busy && wait_cnt < 40) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("held_start_drain", busy, 0);

    // Reset five cycles into a conversion aborts it
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_dac_code", dac_code, 0);
    check("abort_dout", dout, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    ndone = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    convert(0.6, 1'b0, res, lat);
    check("after_abort_code", res, 12'h800);
    check("after_abort_latency", lat, N + 1);

    // Closed-loop sweep with the mismatched DAC
    mismatch_dac = 1'b1;
    prev_code = '0;
    for (int k = 0; k <= 1200; k++) begin
      convert(real'(k) * 0.001, 1'b0, res, lat);
      ideal = int'($floor(real'(k) * 0.001 / 1.2 * 4096.0));
      if (ideal > 4095) ideal = 4095;
      diff = int'(res) - ideal;
      check($sformatf("sweep_monotonic_%0dmV", k), (res >= prev_code), 1);
      check($sformatf("sweep_error_%0dmV", k), (diff <= 12 && diff >= -12), 1);
      prev_code = res;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
